// File: rtl/spi_transfer_arbiter_pkg.sv
// Shared types for the SPI transfer arbiter: FSM state encoding and the
// response record returned to requesters.
package spi_transfer_arbiter_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_DEST_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND,
        ST_GAP
    } state_e;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_DEST_W-1:0] dest;
        logic                  error;
    } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches the request vector starting one past the last
// granted index and returns a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IW'((int'(last_i) + off) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/spi_transfer_arbiter.sv
// Shares one SPI master among several requesters: round-robin grant, single
// transfer in flight, completion timeout and an enforced idle gap.
//
// state      | meaning
// IDLE       | arbitrate; winner's req_ready is high combinationally
// ISSUE      | spi_write_valid pulse with the latched word
// WAIT       | wait for spi_read_valid or timeout
// RESPOND    | resp_valid pulse to the owning requester
// GAP        | enforced idle cycles before the next grant
module spi_transfer_arbiter
    import spi_transfer_arbiter_pkg::*;
#(
    parameter int N_REQUESTERS   = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic [N_REQUESTERS*DATA_WIDTH-1:0] req_data_i,
    input  logic [N_REQUESTERS-1:0]            req_valid_i,
    output logic [N_REQUESTERS-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]              spi_write_data_o,
    output logic                               spi_write_valid_o,
    input  logic [DATA_WIDTH-1:0]              spi_read_data_i,
    input  logic                               spi_read_valid_i,
    output logic [DATA_WIDTH-1:0]              resp_data_o,
    output logic [$clog2(N_REQUESTERS)-1:0]    resp_dest_o,
    output logic                               resp_valid_o,
    output logic                               resp_error_o,
    output logic                               busy_o
);

    localparam int IW       = $clog2(N_REQUESTERS);
    localparam int CNT_MAX  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e                  state_q;
    logic [IW-1:0]           last_q;
    logic [DATA_WIDTH-1:0]   word_q;
    logic                    write_valid_q;
    resp_t                   resp_q;
    logic                    resp_valid_q;
    logic                    busy_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [N_REQUESTERS-1:0] grant;
    logic [IW-1:0]           grant_idx;
    logic                    grant_any;
    logic [DATA_WIDTH-1:0]   req_words [N_REQUESTERS];

    for (genvar g = 0; g < N_REQUESTERS; g++) begin : g_words
        assign req_words[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N  (N_REQUESTERS),
        .IW (IW)
    ) u_rr_arbiter (
        .req_i   (req_valid_i),
        .last_i  (last_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .valid_o (grant_any)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            last_q        <= IW'(N_REQUESTERS - 1);
            word_q        <= '0;
            write_valid_q <= 1'b0;
            resp_q        <= '0;
            resp_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            write_valid_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        word_q        <= req_words[grant_idx];
                        last_q        <= grant_idx;
                        write_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // completion on the terminal-count cycle still counts as success
                    if (spi_read_valid_i) begin
                        resp_q.data  <= MAX_DATA_W'(spi_read_data_i);
                        resp_q.dest  <= MAX_DEST_W'(last_q);
                        resp_q.error <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESPOND;
                    end else if (cnt_q == TO_LAST) begin
                        resp_q.data  <= '0;
                        resp_q.dest  <= MAX_DEST_W'(last_q);
                        resp_q.error <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESPOND;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESPOND: begin
                    cnt_q <= '0;
                    if (GAP_CYCLES == 0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated by reset so every output reads zero while reset is held.
    assign req_ready_o       = (state_q == ST_IDLE && rst_n_i) ? grant : '0;
    assign spi_write_data_o  = word_q;
    assign spi_write_valid_o = write_valid_q;
    assign resp_data_o       = resp_q.data[DATA_WIDTH-1:0];
    assign resp_dest_o       = resp_q.dest[IW-1:0];
    assign resp_valid_o      = resp_valid_q;
    assign resp_error_o      = resp_q.error;
    assign busy_o            = busy_q;

    logic resp_unused;
    assign resp_unused = ^resp_q;

endmodule

// File: tb/tb_spi_transfer_arbiter.sv
// Scoreboard bench for spi_transfer_arbiter: main instance (TIMEOUT 64, GAP 8)
// plus a GAP 0 instance for back-to-back spacing.
module tb_spi_transfer_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam logic [31:0] MASK  = 32'h5A5A_A5A5;
    localparam logic [31:0] MASK0 = 32'h0F0F_0F0F;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  dest;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   spi_write_data_o;
    logic            spi_write_valid_o;
    logic [DW-1:0]   spi_read_data;
    logic            spi_read_valid;
    logic [DW-1:0]   resp_data;
    logic [1:0]      resp_dest;
    logic            resp_valid;
    logic            resp_error;
    logic            busy;

    logic [N*DW-1:0] req_data0;
    logic [N-1:0]    req_valid0;
    logic [N-1:0]    req_ready0;
    logic [DW-1:0]   wdata0;
    logic            wvalid0;
    logic [DW-1:0]   rdata0;
    logic            rvalid0;
    logic [DW-1:0]   resp_data0;
    logic [1:0]      resp_dest0;
    logic            resp_valid0;
    logic            resp_error0;
    logic            busy0;

    spi_transfer_arbiter #(
        .N_REQUESTERS(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64), .GAP_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .spi_write_data_o(spi_write_data_o), .spi_write_valid_o(spi_write_valid_o),
        .spi_read_data_i(spi_read_data), .spi_read_valid_i(spi_read_valid),
        .resp_data_o(resp_data), .resp_dest_o(resp_dest), .resp_valid_o(resp_valid),
        .resp_error_o(resp_error), .busy_o(busy)
    );

    spi_transfer_arbiter #(
        .N_REQUESTERS(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64), .GAP_CYCLES(0)
    ) dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_data_i(req_data0), .req_valid_i(req_valid0), .req_ready_o(req_ready0),
        .spi_write_data_o(wdata0), .spi_write_valid_o(wvalid0),
        .spi_read_data_i(rdata0), .spi_read_valid_i(rvalid0),
        .resp_data_o(resp_data0), .resp_dest_o(resp_dest0), .resp_valid_o(resp_valid0),
        .resp_error_o(resp_error0), .busy_o(busy0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // SPI master model for the main instance
    int          spi_delay = 0;
    bit          spi_fixed = 1'b0;
    logic [31:0] spi_fixed_word = '0;
    int          spi_cd = 0;
    logic [31:0] spi_word = '0;
    int          stray_cnt = 0;
    int          stray_done = 0;

    always @(negedge clk) begin
        spi_read_valid = 1'b0;
        if (spi_cd > 0) begin
            spi_cd--;
            if (spi_cd == 0) begin
                spi_read_valid = 1'b1;
                spi_read_data  = spi_fixed ? spi_fixed_word : (spi_word ^ MASK);
            end
        end else if (stray_done != stray_cnt) begin
            stray_done++;
            spi_read_valid = 1'b1;
            spi_read_data  = 32'hDEAD_BEEF;
        end
        if (spi_write_valid_o === 1'b1 && spi_delay > 0) begin
            spi_cd   = spi_delay;
            spi_word = spi_write_data_o;
        end
    end

    // Scoreboard monitor for the main instance
    logic [31:0] exp_wr[$];
    exp_t        exp_resp[$];
    exp_t        e;
    int          n_wr = 0, n_resp = 0, last_wv_cyc = 0, last_resp_cyc = 0;
    int          wv_times[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (spi_write_valid_o) begin
                n_wr++;
                last_wv_cyc = cyc;
                wv_times.push_back(cyc);
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_data", 64'(spi_write_data_o), 64'(exp_wr.pop_front()));
            end
            if (resp_valid) begin
                n_resp++;
                last_resp_cyc = cyc;
                if (exp_resp.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    e = exp_resp.pop_front();
                    chk("resp_data", 64'(resp_data), 64'(e.data));
                    chk("resp_dest", 64'(resp_dest), 64'(e.dest));
                    chk("resp_error", 64'(resp_error), 64'(e.err));
                end
            end
        end
    end

    // GAP 0 instance: SPI completes one cycle after the write strobe
    logic        wv0_d = 1'b0;
    logic [31:0] wd0_d = '0;
    exp_t        exp0[$];
    exp_t        e0;
    int          n_wr0 = 0, n_resp0 = 0;
    int          wv0_times[$];

    always @(negedge clk) begin
        rvalid0 = wv0_d;
        rdata0  = wd0_d ^ MASK0;
        wv0_d   = wvalid0;
        wd0_d   = wdata0;
        if (rst_n) begin
            if (wvalid0) begin
                n_wr0++;
                wv0_times.push_back(cyc);
            end
            if (resp_valid0) begin
                n_resp0++;
                if (exp0.size() == 0) chk("g0_resp_unexpected", 1, 0);
                else begin
                    e0 = exp0.pop_front();
                    chk("g0_resp_data", 64'(resp_data0), 64'(e0.data));
                    chk("g0_resp_dest", 64'(resp_dest0), 64'(e0.dest));
                end
            end
        end
    end

    task automatic push_resp(input logic [31:0] d, input logic [1:0] dst, input logic er);
        exp_t t;
        t.data = d; t.dest = dst; t.err = er;
        exp_resp.push_back(t);
    endtask

    task automatic wait_resp(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_resp < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, 64'(n_resp), 64'(target));
    endtask

    task automatic wait_wr(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_wr < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, 64'(n_wr), 64'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          k;
        exp_t        t0;

        rst_n = 1'b0; req_data = '0; req_valid = 4'hF;
        req_data0 = '0; req_valid0 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_write_valid", 64'(spi_write_valid_o), 0);
        chk("rst_resp", 64'({resp_valid, resp_error, resp_dest, resp_data}), 0);
        chk("rst_write_data", 64'(spi_write_data_o), 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single request from requester 2
        spi_delay = 20; spi_fixed = 1'b1; spi_fixed_word = 32'h1234;
        req_data[2*DW +: DW] = 32'hCAFE;
        exp_wr.push_back(32'hCAFE);
        push_resp(32'h1234, 2'd2, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 64'(req_ready), 64'(4'b0100));
        @(negedge clk); #1;
        chk("t1_issue_strobe", 64'(spi_write_valid_o), 1);
        chk("t1_issue_ready_low", 64'(req_ready), 0);
        chk("t1_issue_busy", 64'(busy), 1);
        req_valid = '0;
        wait_resp(1, 100, "t1_resp_wait");
        chk("t1_latency", 64'(last_resp_cyc - last_wv_cyc), 21);
        repeat (3) @(negedge clk);
        #1;
        chk("t1_hold_resp_data", 64'(resp_data), 64'(32'h1234));
        chk("t1_hold_resp_dest", 64'(resp_dest), 2);
        chk("t1_hold_write_data", 64'(spi_write_data_o), 64'(32'hCAFE));

        // reset while waiting on the SPI; late completion must be ignored
        repeat (10) @(negedge clk);
        spi_fixed = 1'b0; spi_delay = 20;
        req_data[2*DW +: DW] = 32'hB0B0;
        exp_wr.push_back(32'hB0B0);
        req_valid = 4'b0100;
        @(negedge clk); #1;
        req_valid = '0;
        chk("t3_issue_strobe", 64'(spi_write_valid_o), 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t3_rst_busy", 64'(busy), 0);
        chk("t3_rst_write_data", 64'(spi_write_data_o), 0);
        chk("t3_rst_resp_data", 64'(resp_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        #1;
        chk("t3_after_busy", 64'(busy), 0);
        chk("t3_no_resp", 64'(n_resp), 1);

        // all four held valid: order 0,1,2,3,0 after reset
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        spi_delay = 3;
        for (int i = 0; i < 5; i++) begin
            w = 32'hA000_0000 + 32'(i % 4);
            exp_wr.push_back(w);
            push_resp(w ^ MASK, 2'(i % 4), 1'b0);
        end
        wv_times.delete();
        req_valid = 4'hF;
        #1;
        chk("t2_first_ready", 64'(req_ready), 64'(4'b0001));
        wait_wr(7, 200, "t2_wr_wait");
        req_valid = '0;
        wait_resp(6, 100, "t2_resp_wait");
        for (int i = 1; i < 5; i++)
            chk("t2_spacing_gap8", 64'(wv_times[i] - wv_times[i-1]), 14);

        // gap length and stray completions in GAP and IDLE
        repeat (10) @(negedge clk);
        spi_delay = 2;
        w = 32'h1111_0001;
        req_data[1*DW +: DW] = w;
        exp_wr.push_back(w);
        push_resp(w ^ MASK, 2'd1, 1'b0);
        req_valid = 4'b0010;
        @(negedge clk); #1;
        req_valid = '0;
        wait_resp(7, 50, "t4_resp_wait");
        stray_cnt++;
        repeat (8) @(negedge clk);
        #1;
        chk("t4_gap_last_busy", 64'(busy), 1);
        @(negedge clk); #1;
        chk("t4_gap_end_idle", 64'(busy), 0);
        stray_cnt++;
        repeat (5) @(negedge clk);
        #1;
        chk("t4_idle_stray_busy", 64'(busy), 0);
        chk("t4_no_extra_resp", 64'(n_resp), 7);
        chk("t4_hold_resp_data", 64'(resp_data), 64'(w ^ MASK));

        // no completion: timeout
        spi_delay = 0;
        w = 32'h3333_0003;
        req_data[3*DW +: DW] = w;
        exp_wr.push_back(w);
        push_resp(32'h0, 2'd3, 1'b1);
        req_valid = 4'b1000;
        @(negedge clk); #1;
        req_valid = '0;
        wait_resp(8, 120, "t5_resp_wait");
        chk("t5_timeout_latency", 64'(last_resp_cyc - last_wv_cyc), 65);

        // completion on the terminal-count cycle wins over timeout
        repeat (12) @(negedge clk);
        spi_delay = 64;
        w = 32'h0000_00F0;
        req_data[0 +: DW] = w;
        exp_wr.push_back(w);
        push_resp(w ^ MASK, 2'd0, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk); #1;
        req_valid = '0;
        wait_resp(9, 120, "t6_resp_wait");
        chk("t6_boundary_latency", 64'(last_resp_cyc - last_wv_cyc), 65);

        // GAP 0 instance, requesters 0 and 1 queued
        req_data0[0 +: DW]  = 32'hD000_0000;
        req_data0[DW +: DW] = 32'hD000_0001;
        for (int i = 0; i < 4; i++) begin
            t0.data = (32'hD000_0000 + 32'(i % 2)) ^ MASK0;
            t0.dest = 2'(i % 2);
            t0.err  = 1'b0;
            exp0.push_back(t0);
        end
        req_valid0 = 4'b0011;
        k = 0;
        while (n_wr0 < 4 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        req_valid0 = '0;
        chk("g0_wr_count", 64'(n_wr0), 4);
        k = 0;
        while (n_resp0 < 4 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("g0_resp_count", 64'(n_resp0), 4);
        for (int i = 1; i < wv0_times.size(); i++)
            chk("g0_spacing_gap0", 64'(wv0_times[i] - wv0_times[i-1]), 4);

        repeat (5) @(negedge clk);
        chk("wr_queue_empty", 64'(exp_wr.size()), 0);
        chk("resp_queue_empty", 64'(exp_resp.size()), 0);
        chk("g0_queue_empty", 64'(exp0.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
